// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT,
    StDone  = ST_DONE
  } state_e;

  // Bit counter width: clog2(width), never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder, purely combinational.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a fed-back carry register.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fa_s, fa_c;
`ifdef SERIAL_ADDER_OVF_EN
  logic             cmsb_q, cmsb_d;
`endif

  fa_cell u_fa_cell (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    cmsb_d    = cmsb_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
          cmsb_d  = 1'b0;
`endif
          state_d = StShift;
        end
      end
      StShift: begin
        busy     = 1'b1;
        // New sum bit enters at the MSB so the LSB-first result ends up aligned.
        sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        carry_d  = fa_c;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
`ifdef SERIAL_ADDER_OVF_EN
          cmsb_d  = carry_q;
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      cmsb_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      cmsb_q   <= cmsb_d;
`endif
    end
  end

  assign sum  = sum_sh_q;
  assign cout = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf  = cmsb_q ^ carry_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8, 1 and 16 (instances 0, 1, 2).
module tb_serial_adder;

  logic clk;
  logic rst_n;
  logic [2:0] in_valid, out_ready, cin, in_ready, out_valid, cout, busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic [2:0] ovf;
`endif
  logic [7:0]  a8, b8, sum8;
  logic [0:0]  a1, b1, sum1;
  logic [15:0] a16, b16, sum16;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a8), .b(b8), .cin(cin[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum8), .cout(cout[0]), .busy(busy[0])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf[0])
`endif
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a1), .b(b1), .cin(cin[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum1), .cout(cout[1]), .busy(busy[1])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf[1])
`endif
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a16), .b(b16), .cin(cin[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum(sum16), .cout(cout[2]), .busy(busy[2])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf[2])
`endif
  );

  function automatic int wid(input int k);
    case (k)
      0:       return 8;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic logic [15:0] get_sum(input int k);
    case (k)
      0:       return {8'h00, sum8};
      1:       return {15'h0000, sum1};
      default: return sum16;
    endcase
  endfunction

  task automatic drive(input int k, input logic [15:0] a, input logic [15:0] b, input logic c);
    case (k)
      0:       begin a8 = a[7:0]; b8 = b[7:0]; end
      1:       begin a1 = a[0:0]; b1 = b[0:0]; end
      default: begin a16 = a; b16 = b; end
    endcase
    cin[k] = c;
  endtask

  function automatic exp_t model(input int k, input logic [15:0] a, input logic [15:0] b,
                                 input logic c);
    int          w;
    logic [16:0] m, full;
    logic [15:0] aa, bb;
    exp_t        r;
    w    = wid(k);
    m    = (17'd1 << w) - 17'd1;
    aa   = a & m[15:0];
    bb   = b & m[15:0];
    full = {1'b0, aa} + {1'b0, bb} + {16'h0000, c};
    r.sum  = full[15:0] & m[15:0];
    r.cout = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
    return r;
  endfunction

  task automatic push(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic exp_t pop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int k);
    check({tag, "_in_ready"}, 32'(in_ready[k]), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid[k]), 32'd0);
    check({tag, "_busy"}, 32'(busy[k]), 32'd0);
  endtask

  // One transaction: drive at a negedge, push expectation, wait for result, stall, pop+compare.
  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic c,
                        input int stall, input bit pulse, input bit chk_lat);
    exp_t e;
    int   lat;
    @(negedge clk);
    check("accept_in_ready", 32'(in_ready[k]), 32'd1);
    drive(k, a, b, c);
    in_valid[k] = 1'b1;
    push(k, model(k, a, b, c));
    @(negedge clk);
    in_valid[k] = 1'b0;
    drive(k, 16'($urandom), 16'($urandom), 1'($urandom));
    check("shift_busy", 32'(busy[k]), 32'd1);
    lat = 0;
    while (!out_valid[k] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_timeout", 32'(out_valid[k]), 32'd1);
    if (chk_lat) check("latency", 32'(lat), 32'(wid(k)));
    e = pop(k);
    for (int i = 0; i < stall; i++) begin
      check("stall_out_valid", 32'(out_valid[k]), 32'd1);
      check("stall_in_ready", 32'(in_ready[k]), 32'd0);
      check("stall_sum", 32'(get_sum(k)), 32'(e.sum));
      check("stall_cout", 32'(cout[k]), 32'(e.cout));
      if (pulse && i == 1) begin
        in_valid[k] = 1'b1;
        drive(k, 16'($urandom), 16'($urandom), 1'($urandom));
      end else begin
        in_valid[k] = 1'b0;
      end
      @(negedge clk);
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    check("result_out_valid", 32'(out_valid[k]), 32'd1);
    check("result_sum", 32'(get_sum(k)), 32'(e.sum));
    check("result_cout", 32'(cout[k]), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
    check("result_ovf", 32'(ovf[k]), 32'(e.ovf));
`endif
    @(negedge clk);
    out_ready[k] = 1'b0;
    check_idle("post", k);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    cin       = '0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_idle("in_reset", k);
      check("in_reset_sum", 32'(get_sum(k)), 32'd0);
      check("in_reset_cout", 32'(cout[k]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_idle("after_reset", k);

    // Directed WIDTH=8 cases, including exact latency.
    run_op(0, 16'h3C, 16'h5A, 1'b0, 0, 1'b0, 1'b1);
    run_op(0, 16'hFF, 16'h01, 1'b0, 0, 1'b0, 1'b1);
    run_op(0, 16'hFF, 16'hFF, 1'b1, 0, 1'b0, 1'b1);
    // Backpressure with a stray in_valid pulse while the result is held.
    run_op(0, 16'h12, 16'h34, 1'b1, 5, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_idle("pulse_ignored", 0);

    // Reset in the middle of SHIFT discards the in-flight result.
    @(negedge clk);
    drive(0, 16'hAA, 16'h55, 1'b1);
    in_valid[0] = 1'b1;
    push(0, model(0, 16'hAA, 16'h55, 1'b1));
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_shift_busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", 32'(out_valid[0]), 32'd0);
    check("mid_reset_sum", 32'(sum8), 32'd0);
    check("mid_reset_busy", 32'(busy[0]), 32'd0);
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("mid_reset_release", 0);
    run_op(0, 16'h01, 16'h01, 1'b0, 0, 1'b0, 1'b1);

    // Signed overflow corner cases.
    run_op(0, 16'h7F, 16'h01, 1'b0, 0, 1'b0, 1'b0);
    run_op(0, 16'h80, 16'h80, 1'b0, 0, 1'b0, 1'b0);
    run_op(0, 16'h10, 16'h20, 1'b0, 0, 1'b0, 1'b0);

    // Latency at the width extremes.
    run_op(1, 16'h1, 16'h1, 1'b1, 0, 1'b0, 1'b1);
    run_op(2, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b1);

    // Random traffic with output stalls.
    for (int n = 0; n < 500; n++) begin
      run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b0, 1'b0);
    end
    for (int n = 0; n < 500; n++) begin
      run_op(2, 16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single 1-bit full-adder cell, plus a carry register fed back each cycle.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Adds them LSB-first, one bit per clock, then presents the WIDTH-bit sum and carry-out on a valid/ready output.
- Sits downstream of operand sources and trades latency for area against a ripple-carry adder.

Parameters:
- WIDTH, 8, operand/sum width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, cin are valid this cycle.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered sum.
- cout  output  1  registered carry-out.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; operand shift registers, sum register, carry register and bit counter all 0.
- Outputs during and after reset: in_ready=1, out_valid=0, sum=0, cout=0, busy=0.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0; go to SHIFT.
  - in_valid low: stay in IDLE.
- SHIFT, each cycle:
  - Full-adder cell computes s, c from a_sh[0], b_sh[0], carry.
  - sum_sh <= {s, sum_sh[WIDTH-1:1]}; carry <= c.
  - a_sh and b_sh shift right by 1; cnt <= cnt+1.
  - When cnt==WIDTH-1: go to DONE.
  - in_ready=0; in_valid is ignored.
- DONE:
  - out_valid=1; sum=sum_sh, cout=carry.
  - Outputs held stable until out_ready is sampled high, then go to IDLE.
  - Returning to IDLE deasserts out_valid and asserts in_ready the next cycle.
- Latency: acceptance edge E0; out_valid rises after edge E(WIDTH), i.e. WIDTH cycles after acceptance.
- Throughput: one operation per WIDTH+2 cycles minimum (with out_ready held high).
- No overlap: a new operand is never accepted in the same cycle as the result handshake.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned, exact.
- WIDTH=1: SHIFT lasts exactly one cycle.
- cnt width is clog2(WIDTH) bits, minimum 1.
- Reset mid-operation (any state): the in-flight result is discarded and never presented; the block returns to IDLE.
- Inputs a, b, cin need only be stable in the acceptance cycle.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), signed two's-complement overflow.
  - ovf = carry into MSB XOR carry out of MSB; the carry into the MSB is captured during the final SHIFT cycle.
  - ovf is valid with out_valid and resets to 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/header serial_adder_pkg: state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
- Same header holds a CNT_W helper (clog2 of WIDTH, minimum 1).
- One sub-module: fa_cell (x, y, cin -> s, cout), purely combinational, instantiated once.

Test Plan:
- WIDTH=8, a=0x3C, b=0x5A, cin=0, out_ready=1 -> out_valid 8 cycles after accept; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: out_ready low for 5 cycles in DONE -> sum and cout held, out_valid=1, in_ready=0. A new in_valid pulse in that window is ignored. out_ready=1 -> IDLE next cycle.
- Reset mid-operation: assert rst_n=0 at SHIFT cycle 4 -> out_valid=0, sum=0, busy=0 immediately. After release: in_ready=1; the next op 0x01+0x01 gives 0x02.
- SERIAL_ADDER_OVF_EN defined: 0x7F+0x01 -> sum=0x80, ovf=1. 0x80+0x80 -> sum=0x00, cout=1, ovf=1. 0x10+0x20 -> ovf=0.
- Random: 1000 random a/b/cin with random out_ready stalls, WIDTH=1 and WIDTH=16 -> {cout,sum} matches the reference model a+b+cin every transaction.
